uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial UART receiver, the receive-side counterpart of uart_tx.
- Frame format: 8N1, LSB first, line idles high.
- Runs on its own clock at OVERSAMPLE x baud. Default is 16 x 9600 = 153.6 kHz.
- Recovers each byte, presents it on a parallel output and flags framing and parity errors.
- Input data_in connects directly to a uart_tx data_out or to an external pin.

Parameters:
- OVERSAMPLE, 16, rx_clk cycles per bit; must be even and >= 4.
- DATA_BITS, 8, data bits per frame; fixed at 8 for this revision.

Ports:
- rx_clk  input  1  receive clock, OVERSAMPLE x baud rate; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  receiver enable; 0 holds the block in IDLE.
- data_in  input  1  serial line, asynchronous to rx_clk, idle high.
- data_out  output  8  last correctly received byte.
- start  output  1  one-cycle pulse when a start bit is validated.
- busy  output  1  high from start validation until frame end or abort.
- done  output  1  one-cycle pulse when data_out is updated with a good frame.
- frame_err  output  1  sticky, set when the stop bit samples low.
- parity_err  output  1  sticky parity flag; constant 0 when the option is compiled out.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counters=0, data_out=8'h00, start/busy/done/frame_err/parity_err=0. Both synchronizer flops reset to 1.
- Input path: data_in passes through a 2-flop synchronizer (rxs). The FSM uses only rxs.
- FSM states: IDLE, START, DATA, PARITY (only with option), STOP, WAIT_HIGH.
- Counters:
  - sample counter cnt, 0..OVERSAMPLE-1.
  - bit counter bitn, 0..7.
- IDLE:
  - When en=1 and rxs=0: go to START, cnt=0.
  - frame_err and parity_err clear on this transition.
- START:
  - At cnt==OVERSAMPLE/2-1, sample rxs.
  - rxs=1: glitch; return to IDLE, no start pulse.
  - rxs=0: pulse start, busy=1, go to DATA with cnt=0, bitn=0.
- DATA:
  - Each time cnt==OVERSAMPLE-1, sample rxs (mid-bit).
  - The sampled bit shifts into shift_reg MSB; shift_reg shifts right, so the first bit ends up in bit 0.
  - cnt resets to 0 and bitn increments.
  - After bitn==7 is sampled: go to PARITY if the option is compiled in, else STOP.
- STOP: at cnt==OVERSAMPLE-1, sample rxs.
  - rxs=1: data_out<=shift_reg, done=1 for one cycle, busy=0, go to IDLE.
  - rxs=0: frame_err=1, data_out unchanged, no done, busy=0, go to WAIT_HIGH.
- WAIT_HIGH: stay until rxs=1, then go to IDLE. This prevents a break condition from retriggering.
- Timing (no parity):
  - T0 = the rx_clk edge at which data_in is first captured low.
  - Start is validated at edge T0+10, and start is high for the following cycle.
  - Data bit i is sampled at edge T0+10+16*(i+1).
  - done asserts at edge T0+154. With parity, done asserts at T0+170.
- Back-to-back frames: a new start bit immediately after the stop mid-sample is accepted, because IDLE is re-entered on the cycle after done.
- en=0 mid-frame: abort to IDLE on the next edge, busy=0, no done, data_out unchanged.
- rst low mid-frame: immediate return to reset values, and any partial byte is discarded.
- done and start are never high in the same cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - An even-parity bit follows the 8 data bits; the frame becomes 8E1.
  - PARITY state samples it at cnt==OVERSAMPLE-1.
  - On mismatch with XOR of shift_reg: parity_err=1, and the byte is still written to data_out with done pulsed.
- Undefined: no PARITY state, frame is 8N1, parity_err tied 0.

Test Plan:
- Reset then idle: hold rst=0 for 5 cycles, then release with data_in=1 and en=1 -> all outputs 0, busy never rises over 500 cycles.
- Single frame 0xA5 at 16 clocks/bit (or uart_tx output at the matching rate):
  - start pulse at T0+10.
  - done at T0+154.
  - data_out=8'hA5, frame_err=0.
- Glitch rejection: data_in low for 5 cycles then high -> no start, no busy, state returns to IDLE.
- Framing error: frame 0x3C with stop bit driven 0 for 2 bit times:
  - frame_err=1, no done, data_out keeps its previous value.
  - Next valid frame 0x81 clears frame_err and gives data_out=8'h81.
- Back-to-back frames 0x00 then 0xFF with zero idle gap -> two done pulses 160 cycles apart, data_out 00 then FF.
- Abort and parity:
  - en=0 after data bit 3 of 0x55 -> busy drops next cycle, no done.
  - rst=0 mid-frame -> immediate reset values.
  - With UART_RX_PARITY_EN and a wrong parity bit on 0x07 -> done pulses, data_out=8'h07, parity_err=1.

Source files
------------

// File: rtl/uart_rx.sv
// Oversampled 8N1 UART receiver with a 2-flop input synchronizer and sticky framing error.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report even-parity errors.
module uart_rx #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 rx_clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 data_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 frame_err,
   output logic                 parity_err
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE/2 - 1);
   localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] START     = 3'd1;
   localparam logic [2:0] DATA      = 3'd2;
   localparam logic [2:0] PARITY    = 3'd3;
   localparam logic [2:0] STOP      = 3'd4;
   localparam logic [2:0] WAIT_HIGH = 3'd5;

   logic [1:0]           sync;
   logic                 rxs;
   logic [2:0]           state;
   logic [CW-1:0]        cnt;
   logic [BW-1:0]        bitn;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 par_err_q;

   // Synchronizer resets to the idle-high line level so reset release never looks like a start bit.
   always_ff @(posedge rx_clk or negedge rst) begin
      if (!rst) sync <= 2'b11;
      else      sync <= {sync[0], data_in};
   end
   assign rxs = sync[1];

   always_ff @(posedge rx_clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bitn      <= '0;
         shift_reg <= '0;
         data_out  <= '0;
         start     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         frame_err <= 1'b0;
         par_err_q <= 1'b0;
      end else begin
         start <= 1'b0;
         done  <= 1'b0;
         if (!en) begin
            state <= IDLE;
            cnt   <= '0;
            bitn  <= '0;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (!rxs) begin
                     state     <= START;
                     cnt       <= '0;
                     frame_err <= 1'b0;
                     par_err_q <= 1'b0;
                  end
               end
               START: begin
                  if (cnt == CNT_MID) begin
                     if (rxs) begin
                        state <= IDLE;
                     end else begin
                        start <= 1'b1;
                        busy  <= 1'b1;
                        state <= DATA;
                        cnt   <= '0;
                        bitn  <= '0;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               DATA: begin
                  if (cnt == CNT_END) begin
                     shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
                     cnt       <= '0;
                     bitn      <= bitn + 1'b1;
`ifdef UART_RX_PARITY_EN
                     if (bitn == BIT_LAST) state <= PARITY;
`else
                     if (bitn == BIT_LAST) state <= STOP;
`endif
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
`ifdef UART_RX_PARITY_EN
               PARITY: begin
                  if (cnt == CNT_END) begin
                     if (rxs != ^shift_reg) par_err_q <= 1'b1;
                     cnt   <= '0;
                     state <= STOP;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
`endif
               STOP: begin
                  if (cnt == CNT_END) begin
                     cnt  <= '0;
                     busy <= 1'b0;
                     if (rxs) begin
                        data_out <= shift_reg;
                        done     <= 1'b1;
                        state    <= IDLE;
                     end else begin
                        frame_err <= 1'b1;
                        state     <= WAIT_HIGH;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               // A held-low line (break) must return high before a new frame can start.
               WAIT_HIGH: begin
                  if (rxs) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   assign parity_err = par_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: stimulus tasks queue expected start/done events,
// a negedge monitor pops and checks them against the DUT.
module tb_uart_rx;
   localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
   localparam int PBITS = 1;
`else
   localparam int PBITS = 0;
`endif

   logic       rx_clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       data_in = 1'b1;
   logic [7:0] data_out;
   logic       start, busy, done, frame_err, parity_err;

   uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
      .rx_clk(rx_clk), .rst(rst), .en(en), .data_in(data_in),
      .data_out(data_out), .start(start), .busy(busy), .done(done),
      .frame_err(frame_err), .parity_err(parity_err)
   );

   always #5 rx_clk = ~rx_clk;

   int cyc = 0;
   always @(posedge rx_clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] data;
      int         done_cyc;
      logic       perr;
   } exp_t;

   exp_t done_q[$];
   int   start_q[$];
   exp_t mon_e;
   int   mon_s;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s at cycle %0d", name, cyc);
   endtask

   // Monitor: every start/done pulse must match the head of its queue.
   always @(negedge rx_clk) begin
      if (rst) begin
         if (start) begin
            if (start_q.size() == 0) fail("unexpected start");
            else begin
               mon_s = start_q.pop_front();
               chk("start cycle", cyc, mon_s);
            end
         end
         if (done) begin
            chk("start/done overlap", {31'd0, start}, 32'd0);
            if (done_q.size() == 0) fail("unexpected done");
            else begin
               mon_e = done_q.pop_front();
               chk("done cycle", cyc, mon_e.done_cyc);
               chk("data_out", {24'd0, data_out}, {24'd0, mon_e.data});
               chk("frame_err at done", {31'd0, frame_err}, 32'd0);
               chk("parity_err at done", {31'd0, parity_err}, {31'd0, mon_e.perr});
            end
         end
      end
   end

   task automatic hold(input int n);
      repeat (n) @(negedge rx_clk);
   endtask

   // Sends one whole frame starting at the current negedge; the byte is expected
   // 10 (start mid-sample) + OS per data/parity/stop bit after the first low capture.
   task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      int   t0;
      exp_t e;
      t0 = cyc + 1;
      start_q.push_back(t0 + 10);
      if (!bad_stop) begin
         e.data     = b;
         e.done_cyc = t0 + 10 + OS * (8 + 1 + PBITS);
         e.perr     = (PBITS == 1) ? bad_par : 1'b0;
         done_q.push_back(e);
      end
      data_in = 1'b0;
      hold(OS);
      for (int i = 0; i < 8; i++) begin
         data_in = b[i];
         hold(OS);
      end
      if (PBITS == 1) begin
         data_in = (^b) ^ bad_par;
         hold(OS);
      end
      if (bad_stop) begin
         data_in = 1'b0;
         hold(2 * OS);
         data_in = 1'b1;
      end else begin
         data_in = 1'b1;
         hold(OS);
      end
   endtask

   task automatic partial(input logic [7:0] b, input int nbits);
      int t0;
      t0 = cyc + 1;
      start_q.push_back(t0 + 10);
      data_in = 1'b0;
      hold(OS);
      for (int i = 0; i < nbits; i++) begin
         data_in = b[i];
         hold(OS);
      end
   endtask

   logic [7:0] last_good;
   logic [7:0] rb;
   bit         seen;
   bit         rp;

   initial begin
      rst = 1'b0; en = 1'b1; data_in = 1'b1;
      repeat (5) @(negedge rx_clk);
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset start", {31'd0, start}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
      chk("reset data_out", {24'd0, data_out}, 32'd0);
      chk("reset frame_err", {31'd0, frame_err}, 32'd0);
      chk("reset parity_err", {31'd0, parity_err}, 32'd0);
      rst = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge rx_clk);
         if (busy) seen = 1'b1;
      end
      chk("idle busy never rises", {31'd0, seen}, 32'd0);

      frame(8'hA5, 1'b0, 1'b0);
      last_good = 8'hA5;
      hold(4);
      chk("A5 frame_err", {31'd0, frame_err}, 32'd0);
      chk("A5 data_out", {24'd0, data_out}, 32'hA5);

      // Short low glitch: validated as not-a-start at the half-bit sample.
      data_in = 1'b0;
      hold(5);
      data_in = 1'b1;
      hold(40);
      chk("glitch busy", {31'd0, busy}, 32'd0);

      frame(8'h3C, 1'b0, 1'b1);
      hold(OS);
      chk("framing frame_err", {31'd0, frame_err}, 32'd1);
      chk("framing data_out kept", {24'd0, data_out}, {24'd0, last_good});
      chk("framing busy", {31'd0, busy}, 32'd0);

      frame(8'h81, 1'b0, 1'b0);
      hold(4);
      chk("81 clears frame_err", {31'd0, frame_err}, 32'd0);

      frame(8'h00, 1'b0, 1'b0);
      frame(8'hFF, 1'b0, 1'b0);
      last_good = 8'hFF;
      hold(20);

      partial(8'h55, 4);
      chk("abort busy before", {31'd0, busy}, 32'd1);
      en = 1'b0;
      data_in = 1'b1;
      hold(1);
      chk("abort busy after", {31'd0, busy}, 32'd0);
      en = 1'b1;
      hold(OS * 8);
      chk("abort data_out kept", {24'd0, data_out}, {24'd0, last_good});

      partial(8'h5A, 2);
      data_in = 1'b1;
      rst = 1'b0;
      #1;
      chk("midreset busy", {31'd0, busy}, 32'd0);
      chk("midreset data_out", {24'd0, data_out}, 32'd0);
      chk("midreset start/done", {30'd0, start, done}, 32'd0);
      hold(3);
      rst = 1'b1;
      hold(10);
      chk("post-reset busy", {31'd0, busy}, 32'd0);

`ifdef UART_RX_PARITY_EN
      frame(8'h07, 1'b1, 1'b0);
      hold(4);
      chk("bad parity parity_err", {31'd0, parity_err}, 32'd1);
      chk("bad parity data_out", {24'd0, data_out}, 32'h07);
`endif

      for (int n = 0; n < 24; n++) begin
         rb = 8'($urandom);
         rp = (PBITS == 1) ? bit'($urandom_range(0, 3) == 0) : 1'b0;
         hold($urandom_range(0, 20));
         frame(rb, rp, 1'b0);
      end

      for (int i = 0; i < 400 && (done_q.size() != 0 || start_q.size() != 0); i++)
         @(negedge rx_clk);
      chk("done queue drained", done_q.size(), 32'd0);
      chk("start queue drained", start_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
